// File: rtl/sram_read_ctrl.sv
// Read-side controller for the mixed-signal SRAM array: drives one read wordline,
// waits for the bitlines to settle and senses each differential column pair.
// Optional one-shot re-sample on ambiguous columns: define SRAM_RD_RETRY_EN.
module sram_read_ctrl #(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 8,
    parameter  int SETTLE_CYC = 2,
    localparam int ADDR_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              ready,
    output logic [COLS-1:0]   rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    output real               row_rd [ROWS],
    input  real               bl_rd  [COLS],
    input  real               blb_rd [COLS]
);

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [ADDR_W:0]   ROWS_EXT = (ADDR_W + 1)'(ROWS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WL   = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [COLS-1:0]   r_data;
    logic              r_err;

    logic              w_accept;
    logic              w_cnt_done;
    logic              w_in_range;
    logic              w_retry_ok;
    logic              w_sample;
    logic [COLS-1:0]   w_sense;
    logic [COLS-1:0]   w_amb;

    assign w_accept   = req && (r_state == S_IDLE);
    assign w_cnt_done = (r_state == S_WL) && (r_cnt == CNT_LAST);
    assign w_in_range = ({1'b0, r_addr} < ROWS_EXT);

`ifdef SRAM_RD_RETRY_EN
    logic r_retried;

    assign w_retry_ok = !r_retried && w_in_range && (|w_amb);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retried <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_retried <= 1'b0;
        end else if (w_cnt_done && w_retry_ok) begin
            r_retried <= 1'b1;
        end
    end
`else
    assign w_retry_ok = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_state_nxt = S_WL;
                end
            end
            S_WL: begin
                if (w_cnt_done && !w_retry_ok) begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_addr <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= addr;
            end
            // A retry restarts the settle window with the wordline still high.
            if (r_state != S_WL || w_cnt_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_sense = '0;
        w_amb   = '0;
        for (int c = 0; c < COLS; c++) begin
            if (bl_rd[c] >= VTH && blb_rd[c] < VTH) begin
                w_sense[c] = 1'b1;
            end else if (blb_rd[c] >= VTH && bl_rd[c] < VTH) begin
                w_sense[c] = 1'b0;
            end else begin
                w_amb[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (w_sample) begin
            if (w_in_range) begin
                r_data <= w_sense;
                r_err  <= |w_amb;
            end else begin
                r_data <= '0;
                r_err  <= 1'b1;
            end
        end
    end

    // Only the captured row is ever driven, and only while in WL.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            row_rd[i] = VSS;
            if (r_state == S_WL && w_in_range && r_addr == ADDR_W'(i)) begin
                row_rd[i] = VDD;
            end
        end
    end

    assign ready    = (r_state == S_IDLE);
    assign rd_valid = (r_state == S_DONE) && rst_n;
    assign rd_data  = r_data;
    assign rd_err   = r_err;

endmodule

// File: tb/tb_sram_read_ctrl.sv
// Directed bench for sram_read_ctrl: a 4-row instance for the main reads and a
// 3-row instance for the out-of-range address case.
module tb_sram_read_ctrl;

    localparam int  S   = 2;
    localparam real VDD = 1.5;
    localparam real VSS = 0.0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req4, req3;
    logic [1:0] addr4, addr3;
    logic       ready4, ready3;
    logic [7:0] data4, data3;
    logic       valid4, valid3;
    logic       err4, err3;
    real        row4 [4];
    real        row3 [3];
    real        bl   [8];
    real        blb  [8];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_read_ctrl #(.ROWS(4), .COLS(8), .SETTLE_CYC(S)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .addr(addr4), .ready(ready4),
        .rd_data(data4), .rd_valid(valid4), .rd_err(err4),
        .row_rd(row4), .bl_rd(bl), .blb_rd(blb)
    );

    sram_read_ctrl #(.ROWS(3), .COLS(8), .SETTLE_CYC(S)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .addr(addr3), .ready(ready3),
        .rd_data(data3), .rd_valid(valid3), .rd_err(err3),
        .row_rd(row3), .bl_rd(bl), .blb_rd(blb)
    );

    logic [3:0] wl4;
    logic [2:0] wl3;
    logic       bad_lvl;

    always_comb begin
        wl4     = '0;
        wl3     = '0;
        bad_lvl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (row4[i] == VDD) wl4[i] = 1'b1;
            else if (row4[i] != VSS) bad_lvl = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            if (row3[i] == VDD) wl3[i] = 1'b1;
            else if (row3[i] != VSS) bad_lvl = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bl(input logic [7:0] w);
        for (int c = 0; c < 8; c++) begin
            bl[c]  = w[c] ? VDD : VSS;
            blb[c] = w[c] ? VSS : VDD;
        end
    endtask

    // Issues one request and checks every cycle up to ready returning.
    task automatic run_read(input bit use3, input logic [1:0] a, input logic [3:0] exp_mask,
                            input logic [7:0] exp_data, input logic exp_err, input int wl_cycles,
                            input bit fix_en, input logic [7:0] fix_word, input string tag);
        check({tag, "_ready_pre"}, use3 ? ready3 : ready4, 1);
        if (use3) begin req3 = 1'b1; addr3 = a; end
        else      begin req4 = 1'b1; addr4 = a; end
        step();
        req3 = 1'b0;
        req4 = 1'b0;
        for (int k = 1; k <= wl_cycles; k++) begin
            check($sformatf("%s_wl%0d", tag, k), use3 ? {1'b0, wl3} : wl4, exp_mask);
            check($sformatf("%s_busy%0d", tag, k), use3 ? ready3 : ready4, 0);
            check($sformatf("%s_novalid%0d", tag, k), use3 ? valid3 : valid4, 0);
            check($sformatf("%s_level%0d", tag, k), bad_lvl, 0);
            step();
            if (fix_en && k == S) set_bl(fix_word);
        end
        check({tag, "_valid"}, use3 ? valid3 : valid4, 1);
        check({tag, "_data"}, use3 ? data3 : data4, exp_data);
        check({tag, "_err"}, use3 ? err3 : err4, exp_err);
        check({tag, "_wl_done"}, use3 ? {1'b0, wl3} : wl4, 0);
        step();
        check({tag, "_valid_off"}, use3 ? valid3 : valid4, 0);
        check({tag, "_ready_back"}, use3 ? ready3 : ready4, 1);
        check({tag, "_data_held"}, use3 ? data3 : data4, exp_data);
    endtask

    initial begin
        rst_n = 1'b0;
        req4  = 1'b0;
        req3  = 1'b0;
        addr4 = '0;
        addr3 = '0;
        set_bl(8'hFF);
        step();
        step();
        check("rst_ready", ready4, 1);
        check("rst_valid", valid4, 0);
        check("rst_err", err4, 0);
        check("rst_data", data4, 0);
        check("rst_wl", wl4, 0);
        check("rst_wl3", wl3, 0);
        check("rst_ready3", ready3, 1);
        rst_n = 1'b1;
        step();

        // Row 2, all ones.
        run_read(1'b0, 2'd2, 4'b0100, 8'hFF, 1'b0, S, 1'b0, 8'h00, "row2_ff");

        // Row 1, 0xA5 encoded differentially.
        set_bl(8'hA5);
        run_read(1'b0, 2'd1, 4'b0010, 8'hA5, 1'b0, S, 1'b0, 8'h00, "row1_a5");

        // Column 3 ambiguous at the first sample, then repaired to a valid 1.
        set_bl(8'hFF);
        bl[3]  = 1.2;
        blb[3] = 1.2;
`ifdef SRAM_RD_RETRY_EN
        run_read(1'b0, 2'd0, 4'b0001, 8'hFF, 1'b0, 2 * S, 1'b1, 8'hFF, "amb_col3");
`else
        run_read(1'b0, 2'd0, 4'b0001, 8'hF7, 1'b1, S, 1'b1, 8'hFF, "amb_col3");
`endif

        // Out-of-range row on the 3-row instance.
        set_bl(8'h3C);
        run_read(1'b1, 2'd3, 4'b0000, 8'h00, 1'b1, S, 1'b0, 8'h00, "oor3");

        // Reset during the first WL cycle.
        set_bl(8'hFF);
        req4  = 1'b1;
        addr4 = 2'd1;
        step();
        req4 = 1'b0;
        check("abort_wl_on", wl4, 4'b0010);
        rst_n = 1'b0;
        #1;
        check("abort_valid_low", valid4, 0);
        step();
        rst_n = 1'b1;
        check("abort_wl_off", wl4, 0);
        check("abort_ready", ready4, 1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("abort_novalid%0d", k), valid4, 0);
            step();
        end
        set_bl(8'h5A);
        run_read(1'b0, 2'd3, 4'b1000, 8'h5A, 1'b0, S, 1'b0, 8'h00, "after_abort");

        // Reset asserted in the DONE cycle suppresses the pulse immediately.
        req4  = 1'b1;
        addr4 = 2'd2;
        step();
        req4 = 1'b0;
        step();
        step();
        check("done_rst_valid_pre", valid4, 1);
        rst_n = 1'b0;
        #1;
        check("done_rst_valid_gated", valid4, 0);
        step();
        rst_n = 1'b1;
        check("done_rst_ready", ready4, 1);
        check("done_rst_data", data4, 0);

        // req held high: one read every S+2 cycles, nothing queued.
        set_bl(8'hC3);
        req4  = 1'b1;
        addr4 = 2'd3;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("hold_ready%0d", k), ready4, (k % 4) == 0);
            check($sformatf("hold_valid%0d", k), valid4, (k % 4) == 3);
            check($sformatf("hold_wl%0d", k), wl4, ((k % 4) == 1 || (k % 4) == 2) ? 4'b1000 : 4'b0000);
            if ((k % 4) == 3) check($sformatf("hold_data%0d", k), data4, 8'hC3);
            step();
        end
        req4 = 1'b0;
        check("hold_end_ready", ready4, 1);
        step();
        check("hold_not_queued", ready4, 1);
        check("hold_no_wl", wl4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
